// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD down timer.
//   state_t     : timer FSM states
//   bcd_t       : one BCD digit
//   BCD_MAX     : largest legal BCD digit
//   clamp_digit : forces an out-of-range load digit down to BCD_MAX
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t clamp_digit(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit combinational decrement.
//   digit      : current digit (0..9)
//   dec_en     : decrement request for this digit
//   next_digit : digit after the optional decrement
//   borrow     : high when a 0 wrapped to 9 (propagates to the next digit)
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dec_en,
  output logic [3:0] next_digit,
  output logic       borrow
);

  always_comb begin
    next_digit = digit;
    borrow     = 1'b0;
    if (dec_en) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        borrow     = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with prescaler, pause/resume and done latch.
//   CLOCK_I      : clock, rising edge
//   RESETN_I     : asynchronous active-low reset
//   LOAD_I       : load LOAD_VALUE_I (digits clamped to 9), go IDLE
//   LOAD_VALUE_I : [1]=tens, [0]=units
//   START_I      : start from IDLE (count != 00) or resume from PAUSE
//   STOP_I       : pause while running
//   BCD_COUNT_O  : current count, [1]=tens, [0]=units
//   RUNNING_O    : state is RUN
//   DONE_O       : state is DONE
//   EXPIRED_O    : one-cycle pulse on the 01 -> 00 tick
// Priority every cycle: LOAD_I > STOP_I > START_I.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic            CLOCK_I,
  input  logic            RESETN_I,
  input  logic            LOAD_I,
  input  logic [1:0][3:0] LOAD_VALUE_I,
  input  logic            START_I,
  input  logic            STOP_I,
  output logic [1:0][3:0] BCD_COUNT_O,
  output logic            RUNNING_O,
  output logic            DONE_O,
  output logic            EXPIRED_O
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  state_t          state, state_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [1:0][3:0] count, count_nx;
  logic [1:0][3:0] dec;
  logic [2:0]      carry;
  logic            exp_nx;

  // carry[0] is the tick; each digit's borrow feeds the next digit.
  // carry[2] would mean 00 -> 99, which is never allowed to commit.
  assign carry[0] = (state == RUN) && (presc == PS_LAST);

  for (genvar g = 0; g < 2; g++) begin : g_digit
    bcd_digit_down u_digit (
      .digit      (count[g]),
      .dec_en     (carry[g]),
      .next_digit (dec[g]),
      .borrow     (carry[g+1])
    );
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    count_nx = count;
    exp_nx   = 1'b0;
    if (LOAD_I) begin
      count_nx = {clamp_digit(LOAD_VALUE_I[1]), clamp_digit(LOAD_VALUE_I[0])};
      presc_nx = '0;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (!STOP_I && START_I && (count != '0)) state_nx = RUN;
        RUN: begin
          // A stop freezes both the prescaler and the count, even on a tick.
          if (STOP_I) begin
            state_nx = PAUSE;
          end else if (carry[0]) begin
            presc_nx = '0;
            if (!carry[2]) begin
              count_nx = dec;
              if (dec == '0) begin
                state_nx = DONE;
                exp_nx   = 1'b1;
              end
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        PAUSE: if (!STOP_I && START_I) state_nx = RUN;
        DONE:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state     <= IDLE;
      presc     <= '0;
      count     <= '0;
      RUNNING_O <= 1'b0;
      DONE_O    <= 1'b0;
      EXPIRED_O <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      count     <= count_nx;
      RUNNING_O <= (state_nx == RUN);
      DONE_O    <= (state_nx == DONE);
      EXPIRED_O <= exp_nx;
    end
  end

  assign BCD_COUNT_O = count;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: two instances (PRESCALE 1 and 4) share inputs and
// are compared every cycle against an integer-valued countdown model.
module tb_bcd_down_timer;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic            clk, rst_n, load, start, stop;
  logic [1:0][3:0] lv;
  logic [1:0][3:0] cnt1, cnt4;
  logic            run1, done1, exp1, run4, done4, exp4;

  int m_val[2], m_mode[2], m_ph[2];
  bit m_exp[2];
  int errors = 0;
  int checks = 0;

  bcd_down_timer #(.PRESCALE(1)) u_p1 (
    .CLOCK_I(clk), .RESETN_I(rst_n), .LOAD_I(load), .LOAD_VALUE_I(lv),
    .START_I(start), .STOP_I(stop), .BCD_COUNT_O(cnt1), .RUNNING_O(run1),
    .DONE_O(done1), .EXPIRED_O(exp1));

  bcd_down_timer #(.PRESCALE(4)) u_p4 (
    .CLOCK_I(clk), .RESETN_I(rst_n), .LOAD_I(load), .LOAD_VALUE_I(lv),
    .START_I(start), .STOP_I(stop), .BCD_COUNT_O(cnt4), .RUNNING_O(run4),
    .DONE_O(done4), .EXPIRED_O(exp4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_mode[i] = M_IDLE; m_ph[i] = 0; m_exp[i] = 1'b0;
    end
  endtask

  // Behaviour at one rising edge, from the timer's rules on plain integers.
  task automatic model_edge();
    int p, t, u;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? 1 : 4;
      m_exp[i] = 1'b0;
      if (load) begin
        t = (int'(lv[1]) > 9) ? 9 : int'(lv[1]);
        u = (int'(lv[0]) > 9) ? 9 : int'(lv[0]);
        m_val[i] = t * 10 + u;
        m_ph[i] = 0;
        m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_IDLE) begin
        if (!stop && start && m_val[i] != 0) m_mode[i] = M_RUN;
      end else if (m_mode[i] == M_RUN) begin
        if (stop) m_mode[i] = M_PAUSE;
        else if (m_ph[i] == p - 1) begin
          m_ph[i] = 0;
          if (m_val[i] > 0) m_val[i] = m_val[i] - 1;
          if (m_val[i] == 0) begin
            m_mode[i] = M_DONE;
            m_exp[i] = 1'b1;
          end
        end else m_ph[i] = m_ph[i] + 1;
      end else if (m_mode[i] == M_PAUSE) begin
        if (!stop && start) m_mode[i] = M_RUN;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_cnt1"},  32'(cnt1),  32'(to_bcd(m_val[0])));
    chk({tag, "_run1"},  32'(run1),  32'(m_mode[0] == M_RUN));
    chk({tag, "_done1"}, 32'(done1), 32'(m_mode[0] == M_DONE));
    chk({tag, "_exp1"},  32'(exp1),  32'(m_exp[0]));
    chk({tag, "_cnt4"},  32'(cnt4),  32'(to_bcd(m_val[1])));
    chk({tag, "_run4"},  32'(run4),  32'(m_mode[1] == M_RUN));
    chk({tag, "_done4"}, 32'(done4), 32'(m_mode[1] == M_DONE));
    chk({tag, "_exp4"},  32'(exp4),  32'(m_exp[1]));
  endtask

  task automatic drive(input logic l, input logic [3:0] t, input logic [3:0] u,
                       input logic s, input logic p);
    load = l; lv[1] = t; lv[0] = u; start = s; stop = p;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 chk_all(tag);
  endtask

  initial begin
    int exp_seen;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2 rst_n = 1'b0;
    #2 chk_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // 12 counts down one per cycle at PRESCALE=1
    drive(1, 4'd1, 4'd2, 0, 0); step("ld12");
    drive(0, 0, 0, 1, 0);       step("st12");
    start = 1'b0;
    exp_seen = 0;
    for (int k = 0; k < 15; k++) begin
      step("run12");
      if (exp1) exp_seen++;
      if (k == 10) chk("s32_at01", 32'(cnt1), 32'h01);
      if (k == 11) chk("s32_exp", 32'(exp1), 32'd1);
    end
    chk("s32_pulses", 32'(exp_seen), 32'd1);
    chk("s32_done", 32'(done1), 32'd1);
    chk("s32_zero", 32'(cnt1), 32'h00);

    // out-of-range load digits clamp to 9
    drive(1, 4'hA, 4'hF, 0, 0); step("ldAF");
    chk("s33_99", 32'(cnt1), 32'h99);

    // pause/resume keeps prescaler phase
    drive(1, 4'd0, 4'd3, 0, 0); step("ld03");
    drive(0, 0, 0, 1, 0);       step("st03");
    start = 1'b0;
    repeat (6) step("run03");
    stop = 1'b1; step("stop03");
    stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step("pause03");
      chk("s34_hold", 32'(cnt4), 32'h02);
    end
    start = 1'b1; step("resume03");
    start = 1'b0;
    step("r1");
    chk("s34_r1", 32'(cnt4), 32'h02);
    step("r2");
    chk("s34_r2", 32'(cnt4), 32'h01);
    repeat (4) step("r3");
    chk("s34_done", 32'(done4), 32'd1);

    // load wins over stop and start in RUN
    drive(1, 4'd4, 4'd5, 0, 0); step("ld45");
    drive(0, 0, 0, 1, 0);       step("st45");
    start = 1'b0;
    repeat (2) step("run45");
    drive(1, 4'd4, 4'd5, 1, 1); step("all45");
    chk("s35_cnt", 32'(cnt1), 32'h45);
    chk("s35_run", 32'(run1), 32'd0);
    drive(0, 0, 0, 0, 0);

    // start at 00 stays idle; start in DONE does nothing
    drive(1, 4'd0, 4'd0, 0, 0); step("ld00");
    drive(0, 0, 0, 1, 0);       step("st00");
    chk("s36_idle", 32'(run1), 32'd0);
    chk("s36_noexp", 32'(exp1), 32'd0);
    drive(1, 4'd0, 4'd1, 0, 0); step("ld01");
    drive(0, 0, 0, 1, 0);       step("st01");
    start = 1'b0;
    repeat (2) step("run01");
    start = 1'b1; step("done_st");
    chk("s36_done", 32'(done1), 32'd1);
    chk("s36_exp", 32'(exp1), 32'd0);
    start = 1'b0;

    // reset mid-run clears immediately
    drive(1, 4'd0, 4'd9, 0, 0); step("ld09");
    drive(0, 0, 0, 1, 0);       step("st09");
    start = 1'b0;
    repeat (2) step("run09");
    chk("s37_07", 32'(cnt1), 32'h07);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("midrst");
    repeat (3) step("inrst");
    @(negedge clk) rst_n = 1'b1;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      load  = ($urandom % 20) == 0;
      lv[1] = ($urandom % 2) ? 4'($urandom_range(0, 2)) : 4'($urandom % 16);
      lv[0] = 4'($urandom % 16);
      start = ($urandom % 3) == 0;
      stop  = ($urandom % 10) == 0;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1: clock cycles per count tick; legal range 1..65535.
REQ-002 The block SHALL have port CLOCK_I, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESETN_I, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port LOAD_I, input, 1 bit: parallel load strobe.
REQ-005 The block SHALL have port LOAD_VALUE_I, input, 2 x 4 bits: BCD load value; [0] = units, [1] = tens.
REQ-006 The block SHALL have port START_I, input, 1 bit: start or resume request.
REQ-007 The block SHALL have port STOP_I, input, 1 bit: pause request.
REQ-008 The block SHALL have port BCD_COUNT_O, output, 2 x 4 bits: current count; [0] = units, [1] = tens.
REQ-009 The block SHALL have port RUNNING_O, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port DONE_O, output, 1 bit: high while in DONE.
REQ-011 The block SHALL have port EXPIRED_O, output, 1 bit: one-cycle pulse when the count reaches 00 from RUN.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, PAUSE and DONE, all registered.
REQ-013 Input priority SHALL be LOAD_I > STOP_I > START_I, evaluated every cycle.
REQ-014 LOAD_I=1 in any state SHALL, at the next edge:
- load the count;
- clear the prescaler;
- enter IDLE;
- leave EXPIRED_O low.
REQ-015 On load, any LOAD_VALUE_I digit above 9 SHALL be clamped to 9.
REQ-016 IDLE + START_I SHALL enter RUN when count != 00 and SHALL remain in IDLE when count == 00.
REQ-017 RUN + STOP_I SHALL enter PAUSE; the prescaler value SHALL be retained; no decrement SHALL occur that cycle, even if a tick coincides.
REQ-018 PAUSE + START_I SHALL re-enter RUN, resuming from the retained prescaler value.
REQ-019 DONE SHALL hold the count at 00, ignore START_I and STOP_I, and exit only via LOAD_I.
REQ-020 In RUN, the prescaler SHALL count 0..PRESCALE-1; a tick SHALL occur on the cycle it equals PRESCALE-1, after which it wraps to 0.
REQ-021 On each tick the count SHALL decrement by one in BCD:
- units 1..9 -> units-1;
- units 0 -> units 9 with a borrow to tens;
- tens decrements by 1 on borrow.
REQ-022 A tick decrementing 01 -> 00 SHALL enter DONE in the same edge, with EXPIRED_O high for exactly that next cycle.
REQ-023 With PRESCALE=1, the count SHALL change on every RUN cycle; N ticks from value V SHALL give V-N, observable N cycles after entering RUN.
REQ-024 Outputs SHALL be register-driven, with no combinational path from inputs to outputs.
REQ-025 Count 00 SHALL never wrap to 99.

Reset
REQ-026 RESETN_I=0 SHALL immediately force:
- state IDLE;
- BCD_COUNT_O = 00;
- prescaler = 0;
- RUNNING_O, DONE_O and EXPIRED_O = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the countdown with no EXPIRED_O pulse.
REQ-028 After reset release, the block SHALL act on inputs from the first rising edge.

Structure
REQ-029 A shared package bcd_timer_pkg SHALL hold:
- the FSM state enum;
- the 4-bit BCD digit typedef;
- the constant BCD_MAX = 9.
REQ-030 A sub-module bcd_digit_down SHALL implement a single-digit combinational decrement, with inputs digit and decrement-enable and outputs next digit and borrow-out; it SHALL be instantiated twice and chained.
REQ-031 The prescaler SHALL be sized $clog2(PRESCALE) bits, minimum 1.

Verification
REQ-032 Scenario: reset, load 12, START, PRESCALE=1 -> count 11, 10, 09, ..., 01, 00 on consecutive cycles; EXPIRED_O pulses once with count 00; DONE_O high thereafter.
REQ-033 Scenario: load tens=A, units=F -> BCD_COUNT_O = 99 on the next cycle.
REQ-034 Scenario: PRESCALE=4, load 03, START, STOP after 6 cycles, wait 10 cycles, START ->
- count holds at 02 during PAUSE;
- the next decrement occurs 2 cycles after resume;
- the total is 12 RUN cycles to 00.
REQ-035 Scenario: same-cycle LOAD_I=1, START_I=1, STOP_I=1 in RUN with value 45 -> count 45, state IDLE, RUNNING_O=0.
REQ-036 Scenario: START with count 00 in IDLE -> remains IDLE, no EXPIRED_O; START in DONE -> no change.
REQ-037 Scenario: RESETN_I low mid-RUN at count 07 -> outputs 00/0/0/0 immediately; no EXPIRED_O pulse.
